rv32im_muldiv: RTL
==================

Name: rv32im_muldiv

Overview:
Parametrised M-extension execute unit for the RV32IM pipeline: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It sits beside rv32i_alu in EX.
- Multiply completes in a fixed, configurable latency.
- Divide is iterative, one bit per cycle, with single-cycle special cases.
- Valid/ready on both sides, a flush input, and a writeback tag carried with the result.

Parameters:
WIDTH, 32, datapath width (even, >=8)
MUL_LATENCY, 2, cycles from accept to o_valid for multiply ops (>=1)
TAG_W, 5, width of the pass-through destination tag

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
i_valid  input  1  request valid
o_ready  output  1  unit can accept; high only in IDLE
i_md_op  input  3  operation, encoded as instruction funct3
i_rs1_data  input  WIDTH  operand A (dividend / multiplicand)
i_rs2_data  input  WIDTH  operand B (divisor / multiplier)
i_tag  input  TAG_W  rd tag, returned with the result
i_flush  input  1  kill in-flight op
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_result  output  WIDTH  result
o_tag  output  TAG_W  tag of the result
o_busy  output  1  high in any state except IDLE

Behaviour:
- Reset: asynchronous while rst==0.
  - State=IDLE; o_valid, o_result, o_tag, o_busy=0; all internal registers cleared.
  - o_ready=1 (combinational from IDLE).
- Accept: i_valid && o_ready && !i_flush at a rising edge. This latches operands, op and tag; it is cycle 0.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - op[2]==0 goes to MUL.
  - op[2]==1 goes to DIV, unless a special case applies, then DONE.
- MUL:
  - Full 2*WIDTH product from sign-extended operands:
    - MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU / MUL: both unsigned.
  - MUL returns product[WIDTH-1:0]; the others return product[2*WIDTH-1:WIDTH].
  - Counter holds MUL_LATENCY-1 cycles, then goes to DONE. o_valid first high at cycle MUL_LATENCY.
- DIV:
  - Restoring divide on operand magnitudes (signed ops take absolute values).
  - Counter runs WIDTH iterations, then FIX.
- FIX:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Goes to DONE. o_valid first high at cycle WIDTH+2 (34 at default).
- Divide special cases, resolved in IDLE, o_valid at cycle 1:
  - Divisor 0: quotient = all ones, remainder = dividend (signed and unsigned).
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend, remainder = 0.
- DONE:
  - o_valid=1; o_result and o_tag held stable until i_ready.
  - o_valid && i_ready goes to IDLE. A new request can be accepted the cycle after.
- i_flush:
  - Synchronous. From any state, the next state is IDLE and o_valid=0.
  - A request presented with i_flush is not accepted.
  - A flush in DONE drops the result even if i_ready is high.
- Counter and arithmetic widths:
  - Counter width is $clog2(WIDTH+1).
  - Divide remainder register is WIDTH+1 bits for the trial subtract.
  - No X propagation on the unused opcode path.

Optional Feature:
RV32IM_MD_FUSE_EN:
- When defined:
  - Keep the last completed divide's operands, signedness, quotient and remainder, with a valid bit.
  - A DIV/DIVU/REM/REMU whose operands and signedness match is served from this cache, o_valid at cycle 1.
  - The cache is cleared by reset and by i_flush.
- When undefined: no cache; every non-special divide takes WIDTH+2 cycles.

Decomposition:
- Shared package rv32im_md_pkg holds:
  - md_op_t enum: MD_MUL=3'b000, MD_MULH=001, MD_MULHSU=010, MD_MULHU=011, MD_DIV=100, MD_DIVU=101, MD_REM=110, MD_REMU=111.
  - md_state_t enum for the FSM states.
- Include-header defines for the decoder stay in rv32i_decoder_header.vh.
- One sub-module: rv32im_div_core.
  - Contains the iterative magnitude divider: start/done, WIDTH-cycle counter, quotient/remainder registers.
  - The top level keeps sign handling, special cases, multiply, FSM and handshake.

Test Plan:
1. MUL 7 * 0xFFFFFFFD (-3), tag 5'd9 -> o_result 0xFFFFFFEB, o_tag 9, o_valid exactly at cycle 2; o_ready low in cycles 1..2.
2. Upper-half multiplies:
   - MULH 0x80000000*0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
3. Signed and unsigned divide:
   - DIV 0xFFFFFFEC (-20) / 3 -> 0xFFFFFFFA.
   - REM same operands -> 0xFFFFFFFE.
   - DIVU 100/7 -> 14.
   - Each with o_valid at cycle 34.
4. Special cases, each valid at cycle 1:
   - DIV 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
5. Backpressure and flush:
   - Hold i_ready=0 for 5 cycles in DONE -> o_result/o_tag stable, o_ready=0.
   - Separately, i_flush at cycle 10 of a DIV -> no o_valid, o_ready=1 next cycle.
6. Reset and fuse:
   - Drop rst mid-divide -> o_valid/o_result/o_busy go to 0 without waiting for a clock edge; o_ready=1 after release.
   - With RV32IM_MD_FUSE_EN: DIV 50/7 then REM 50/7 -> REM returns 1 at cycle 1.
   - Without RV32IM_MD_FUSE_EN: REM returns 1 at cycle 34.

Source files
------------

// File: rtl/rv32im_md_pkg.sv
// Shared types for the RV32IM multiply/divide unit: opcode encoding (funct3),
// FSM states and a helper that picks operand signedness for the multiplier.
package rv32im_md_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

    // Returns {rs1_signed, rs2_signed} for the multiply ops.
    function automatic logic [1:0] md_mul_signs(input logic [2:0] op);
        logic [1:0] s;
        s = 2'b00;
        case (md_op_t'(op))
            MD_MULH:   s = 2'b11;
            MD_MULHSU: s = 2'b10;
            default:   s = 2'b00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rv32im_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// o_done is high during the final iteration, so results are stable the cycle after.
module rv32im_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    r_cnt;
    logic             r_run;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_div;

    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_new;

    // r_rem holds the partial remainder already shifted with the next dividend bit.
    assign w_diff    = r_rem - {1'b0, r_div};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_rem_new = w_qbit ? w_diff[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
        end else if (i_abort) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= CW'(WIDTH);
            r_run  <= 1'b1;
            r_div  <= i_divisor;
            r_rem  <= {{WIDTH{1'b0}}, i_dividend[WIDTH-1]};
            r_quot <= {i_dividend[WIDTH-2:0], 1'b0};
        end else if (r_run) begin
            r_rem  <= {w_rem_new, r_quot[WIDTH-1]};
            r_quot <= {r_quot[WIDTH-2:0], w_qbit};
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_run <= 1'b0;
            end
        end
    end

    assign o_busy = r_run;
    assign o_done = r_run && (r_cnt == CW'(1));
    assign o_quot = r_quot;
    // Bit 0 is the unused dividend slot shifted in by the last iteration.
    assign o_rem  = r_rem[WIDTH:1];

endmodule

// File: rtl/rv32im_muldiv.sv
// RV32IM M-extension execute unit: fixed-latency multiply, iterative divide.
// Optional last-divide result cache enabled by defining RV32IM_MD_FUSE_EN.
module rv32im_muldiv
    import rv32im_md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_md_op,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);

    localparam int MCW       = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam int MCNT_INIT = (MUL_LATENCY >= 2) ? (MUL_LATENCY - 2) : 0;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t        r_state, w_state_next;
    logic [2:0]       r_op, w_op_next;
    logic [WIDTH-1:0] r_a, w_a_next;
    logic [WIDTH-1:0] r_b, w_b_next;
    logic [TAG_W-1:0] r_tag, w_tag_next;
    logic [WIDTH-1:0] r_result, w_result_next;
    logic [MCW-1:0]   r_mcnt, w_mcnt_next;
    logic             r_neg_q, w_neg_q_next;
    logic             r_neg_r, w_neg_r_next;

    logic             w_accept;
    logic             w_sdiv_in;
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic             w_div_by0, w_div_ovf, w_div_special;
    logic [WIDTH-1:0] w_special_res;
    logic             w_fuse_hit;
    logic [WIDTH-1:0] w_fuse_res;
    logic             w_div_start, w_div_busy, w_div_done;
    logic [WIDTH-1:0] w_quot, w_rem, w_quot_fix, w_rem_fix;

    logic [2:0]         w_mul_op;
    logic [WIDTH-1:0]   w_mul_a, w_mul_b;
    logic [1:0]         w_mul_sgn;
    logic [2*WIDTH-1:0] w_mul_a_ext, w_mul_b_ext, w_prod;
    logic [WIDTH-1:0]   w_mul_res;

    assign w_accept = i_valid && (r_state == ST_IDLE) && !i_flush;

    // Signed divide ops are DIV/REM (funct3 bit 0 clear).
    assign w_sdiv_in = ~i_md_op[0];
    assign w_a_neg   = w_sdiv_in & i_rs1_data[WIDTH-1];
    assign w_b_neg   = w_sdiv_in & i_rs2_data[WIDTH-1];
    assign w_a_mag   = w_a_neg ? -i_rs1_data : i_rs1_data;
    assign w_b_mag   = w_b_neg ? -i_rs2_data : i_rs2_data;

    assign w_div_by0     = (i_rs2_data == '0);
    assign w_div_ovf     = w_sdiv_in && (i_rs1_data == MOST_NEG) && (i_rs2_data == '1);
    assign w_div_special = w_div_by0 || w_div_ovf;
    always_comb begin
        w_special_res = '0;
        if (w_div_by0) begin
            w_special_res = i_md_op[1] ? i_rs1_data : '1;
        end else begin
            w_special_res = i_md_op[1] ? '0 : i_rs1_data;
        end
    end

    // One multiplier: fed straight from the inputs on accept, otherwise from latched operands.
    assign w_mul_op    = (r_state == ST_IDLE) ? i_md_op    : r_op;
    assign w_mul_a     = (r_state == ST_IDLE) ? i_rs1_data : r_a;
    assign w_mul_b     = (r_state == ST_IDLE) ? i_rs2_data : r_b;
    assign w_mul_sgn   = md_mul_signs(w_mul_op);
    assign w_mul_a_ext = {{WIDTH{w_mul_sgn[1] & w_mul_a[WIDTH-1]}}, w_mul_a};
    assign w_mul_b_ext = {{WIDTH{w_mul_sgn[0] & w_mul_b[WIDTH-1]}}, w_mul_b};
    assign w_prod      = w_mul_a_ext * w_mul_b_ext;
    assign w_mul_res   = (w_mul_op[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

    assign w_quot_fix = r_neg_q ? -w_quot : w_quot;
    assign w_rem_fix  = r_neg_r ? -w_rem  : w_rem;

    rv32im_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_abort    (i_flush),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

`ifdef RV32IM_MD_FUSE_EN
    logic             r_fc_valid;
    logic             r_fc_signed;
    logic [WIDTH-1:0] r_fc_a, r_fc_b, r_fc_q, r_fc_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fc_valid  <= 1'b0;
            r_fc_signed <= 1'b0;
            r_fc_a      <= '0;
            r_fc_b      <= '0;
            r_fc_q      <= '0;
            r_fc_r      <= '0;
        end else if (i_flush) begin
            r_fc_valid <= 1'b0;
        end else if (r_state == ST_FIX) begin
            r_fc_valid  <= 1'b1;
            r_fc_signed <= ~r_op[0];
            r_fc_a      <= r_a;
            r_fc_b      <= r_b;
            r_fc_q      <= w_quot_fix;
            r_fc_r      <= w_rem_fix;
        end
    end

    assign w_fuse_hit = r_fc_valid && (r_fc_a == i_rs1_data) && (r_fc_b == i_rs2_data)
                        && (r_fc_signed == w_sdiv_in);
    assign w_fuse_res = i_md_op[1] ? r_fc_r : r_fc_q;
`else
    assign w_fuse_hit = 1'b0;
    assign w_fuse_res = '0;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_op_next     = r_op;
        w_a_next      = r_a;
        w_b_next      = r_b;
        w_tag_next    = r_tag;
        w_result_next = r_result;
        w_mcnt_next   = r_mcnt;
        w_neg_q_next  = r_neg_q;
        w_neg_r_next  = r_neg_r;
        w_div_start   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_op_next    = i_md_op;
                    w_a_next     = i_rs1_data;
                    w_b_next     = i_rs2_data;
                    w_tag_next   = i_tag;
                    w_neg_q_next = w_a_neg ^ w_b_neg;
                    w_neg_r_next = w_a_neg;
                    if (!i_md_op[2]) begin
                        if (MUL_LATENCY == 1) begin
                            w_result_next = w_mul_res;
                            w_state_next  = ST_DONE;
                        end else begin
                            w_mcnt_next  = MCW'(MCNT_INIT);
                            w_state_next = ST_MUL;
                        end
                    end else if (w_div_special) begin
                        w_result_next = w_special_res;
                        w_state_next  = ST_DONE;
                    end else if (w_fuse_hit) begin
                        w_result_next = w_fuse_res;
                        w_state_next  = ST_DONE;
                    end else begin
                        w_div_start  = 1'b1;
                        w_state_next = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (r_mcnt == '0) begin
                    w_result_next = w_mul_res;
                    w_state_next  = ST_DONE;
                end else begin
                    w_mcnt_next = r_mcnt - MCW'(1);
                end
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_result_next = r_op[1] ? w_rem_fix : w_quot_fix;
                w_state_next  = ST_DONE;
            end
            ST_DONE: begin
                if (i_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (i_flush) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_tag    <= '0;
            r_result <= '0;
            r_mcnt   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_op     <= w_op_next;
            r_a      <= w_a_next;
            r_b      <= w_b_next;
            r_tag    <= w_tag_next;
            r_result <= w_result_next;
            r_mcnt   <= w_mcnt_next;
            r_neg_q  <= w_neg_q_next;
            r_neg_r  <= w_neg_r_next;
        end
    end

    assign o_ready  = (r_state == ST_IDLE);
    assign o_busy   = (r_state != ST_IDLE) || w_div_busy;
    assign o_valid  = (r_state == ST_DONE);
    assign o_result = r_result;
    assign o_tag    = r_tag;

endmodule
